// File: rtl/play_motion_if.sv
// Bundle of the strobes, controls and status that pass between the playfield
// sequencer and the motion controller.
interface play_motion_if #(
    parameter int unsigned POS_W   = 17,
    parameter int unsigned FRAC    = 1,
    parameter int unsigned SPEED_W = 3,
    parameter int unsigned PROG_W  = 26
) ();
    logic                  move_tick;
    logic                  frame_tick;
    logic                  play_signal;
    logic                  restart;
    logic                  press;
    logic [SPEED_W-1:0]    speed;
    logic                  fail_in;
    logic [PROG_W-1:0]     total_len;
    logic [PROG_W-1:0]     unit_len;
    logic [POS_W-FRAC-1:0] head_x;
    logic [POS_W-FRAC-1:0] head_y;
    logic [1:0]            state;
    logic                  direction;
    logic [9:0]            progress;
    logic                  song_done;
    logic                  progress_busy;

    modport master (
        output move_tick, frame_tick, play_signal, restart, press, speed, fail_in,
               total_len, unit_len,
        input  head_x, head_y, state, direction, progress, song_done, progress_busy
    );

    modport slave (
        input  move_tick, frame_tick, play_signal, restart, press, speed, fail_in,
               total_len, unit_len,
        output head_x, head_y, state, direction, progress, song_done, progress_busy
    );
endinterface

// File: rtl/play_motion_ctrl.sv
// Play-state FSM, snake-head motion with turn handling, and song progress in
// permille computed by a 10-cycle restoring divider.
module play_motion_ctrl #(
    parameter int unsigned POS_W    = 17,
    parameter int unsigned FRAC     = 1,
    parameter int unsigned SPEED_W  = 3,
    parameter int unsigned STEP_OFS = 4,
    parameter int unsigned PROG_W   = 26,
    parameter int unsigned X0       = 672,
    parameter int unsigned Y0       = 480,
    parameter int unsigned TURN_MIN = 697
) (
    input  logic         clk,
    input  logic         reset,
    play_motion_if.slave bus
);
    localparam int unsigned HEAD_W = POS_W - FRAC;
    localparam int unsigned QW     = 10;
    localparam int unsigned DIV_W  = PROG_W + QW - 1;

    typedef enum logic [1:0] {
        StNotPlaying = 2'd0,
        StPlaying    = 2'd1,
        StPaused     = 2'd2,
        StStopped    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [POS_W-1:0]   raw_x_q, raw_x_d, raw_y_q, raw_y_d;
    logic               dir_q, dir_d, pend_q, pend_d;
    logic [PROG_W-1:0]  prog_raw_q, prog_raw_d;
    logic [HEAD_W-1:0]  head_x_q, head_y_q;
    logic               div_busy_q, div_busy_d;
    logic [3:0]         div_cnt_q, div_cnt_d;
    logic [PROG_W-1:0]  div_rem_q, div_rem_d;
    logic [DIV_W-1:0]   div_dsr_q, div_dsr_d;
    logic [QW-1:0]      div_quo_q, div_quo_d;
    logic [QW-1:0]      progress_q, progress_d;

    logic [SPEED_W-1:0] speed;
    logic               song_done, advance, turn, div_start, div_bit;
    logic [POS_W-1:0]   step_pos;
    logic [PROG_W-1:0]  step_prog;
    logic [PROG_W:0]    prog_sum;

    assign speed     = bus.speed;
    assign song_done = prog_raw_q > bus.total_len;
    // A zero speed code is a pause request, so it never produces a step.
    assign advance   = bus.move_tick && (state_q == StPlaying) && (speed != '0);
    assign turn      = (bus.press || pend_q) && (raw_x_q >= POS_W'(TURN_MIN));
    assign step_pos  = POS_W'(speed) + POS_W'(STEP_OFS);
    assign step_prog = PROG_W'(speed) + PROG_W'(STEP_OFS);
    assign prog_sum  = {1'b0, prog_raw_q} + {1'b0, step_prog};

    always_comb begin
        state_d = state_q;
        if (bus.restart) begin
            state_d = StNotPlaying;
        end else begin
            unique case (state_q)
                StNotPlaying: if (bus.play_signal) state_d = StPlaying;
                StPlaying: begin
                    if (bus.fail_in || song_done) state_d = StStopped;
                    else if (speed == '0)         state_d = StPaused;
                end
                StPaused:     if (speed != '0) state_d = StPlaying;
                StStopped:    state_d = StStopped;
                default:      state_d = StNotPlaying;
            endcase
        end
    end

    always_comb begin
        raw_x_d    = raw_x_q;
        raw_y_d    = raw_y_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        prog_raw_d = prog_raw_q;
        progress_d = progress_q;
        div_busy_d = div_busy_q;
        div_cnt_d  = div_cnt_q;
        div_rem_d  = div_rem_q;
        div_dsr_d  = div_dsr_q;
        div_quo_d  = div_quo_q;
        div_start  = 1'b0;
        div_bit    = 1'b0;
        if (bus.restart) begin
            raw_x_d    = POS_W'(X0);
            raw_y_d    = POS_W'(Y0);
            dir_d      = 1'b0;
            pend_d     = 1'b0;
            prog_raw_d = '0;
            progress_d = '0;
            div_busy_d = 1'b0;
        end else begin
            if (advance) begin
                dir_d  = dir_q ^ turn;
                pend_d = 1'b0;
                if (dir_d) raw_y_d = raw_y_q + step_pos;
                else       raw_x_d = raw_x_q + step_pos;
                if (prog_raw_q <= bus.total_len) begin
                    prog_raw_d = prog_sum[PROG_W] ? '1 : prog_sum[PROG_W-1:0];
                    div_start  = 1'b1;
                end
            end else if (bus.press) begin
                pend_d = 1'b1;
            end
            // A fresh start discards any division still in flight.
            if (div_start) begin
                div_busy_d = 1'b1;
                div_cnt_d  = '0;
                div_rem_d  = prog_raw_d;
                div_dsr_d  = DIV_W'(bus.unit_len) << (QW - 1);
                div_quo_d  = '0;
            end else if (div_busy_q) begin
                div_bit = DIV_W'(div_rem_q) >= div_dsr_q;
                if (div_bit) div_rem_d = div_rem_q - PROG_W'(div_dsr_q);
                div_quo_d = {div_quo_q[QW-2:0], div_bit};
                div_dsr_d = div_dsr_q >> 1;
                div_cnt_d = div_cnt_q + 4'd1;
                if (div_cnt_q == 4'(QW - 1)) begin
                    div_busy_d = 1'b0;
                    progress_d = (div_quo_d > 10'd1000) ? 10'd1000 : div_quo_d;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StNotPlaying;
            raw_x_q    <= POS_W'(X0);
            raw_y_q    <= POS_W'(Y0);
            dir_q      <= 1'b0;
            pend_q     <= 1'b0;
            prog_raw_q <= '0;
            progress_q <= '0;
            div_busy_q <= 1'b0;
            div_cnt_q  <= '0;
            div_rem_q  <= '0;
            div_dsr_q  <= '0;
            div_quo_q  <= '0;
            head_x_q   <= HEAD_W'(X0 >> FRAC);
            head_y_q   <= HEAD_W'(Y0 >> FRAC);
        end else begin
            state_q    <= state_d;
            raw_x_q    <= raw_x_d;
            raw_y_q    <= raw_y_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            prog_raw_q <= prog_raw_d;
            progress_q <= progress_d;
            div_busy_q <= div_busy_d;
            div_cnt_q  <= div_cnt_d;
            div_rem_q  <= div_rem_d;
            div_dsr_q  <= div_dsr_d;
            div_quo_q  <= div_quo_d;
            // Latches the pre-update position when a move_tick coincides.
            if (bus.frame_tick) begin
                head_x_q <= raw_x_q[POS_W-1:FRAC];
                head_y_q <= raw_y_q[POS_W-1:FRAC];
            end
        end
    end

    assign bus.head_x        = head_x_q;
    assign bus.head_y        = head_y_q;
    assign bus.state         = state_q;
    assign bus.direction     = dir_q;
    assign bus.progress      = progress_q;
    assign bus.song_done     = song_done;
    assign bus.progress_busy = div_busy_q;
endmodule
